// File: rtl/imm_pkg.sv
// Shared encodings for the pipelined immediate generator: format selects and
// skid-buffer occupancy states.
package imm_pkg;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_U    = 3'b011;
    localparam logic [2:0] IMM_J    = 3'b100;
    localparam logic [2:0] IMM_Z    = 3'b101;
    localparam logic [2:0] IMM_ILL1 = 3'b110;
    localparam logic [2:0] IMM_ILL2 = 3'b111;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned SRC_W   = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/imm_expand.sv
// Combinational immediate decode for all RV base formats plus CSR zimm,
// extended to XLEN.
module imm_expand
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INSTR_W-1:0] instr,
    input  logic [SRC_W-1:0]   imm_src,
    output logic [XLEN-1:0]    imm,
    output logic               illegal
);

    logic [31:0] imm32;

    // Z and illegal leave bit 31 clear, so one sign extension serves every format.
    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (imm_src)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            IMM_Z:   imm32 = {27'b0, instr[19:15]};
            default: illegal = 1'b1;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake; SKID selects a
// two-entry skid buffer (registered in_ready) or a single pipeline register.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5,
    parameter int unsigned SKID  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [SRC_W-1:0]   in_imm_src,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_imm,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("imm_gen_pipe: TAG_W must be at least 1");
    end

    logic [XLEN-1:0] exp_imm;
    logic            exp_ill;

    imm_expand #(.XLEN(XLEN)) u_expand (
        .instr   (in_instr),
        .imm_src (in_imm_src),
        .imm     (exp_imm),
        .illegal (exp_ill)
    );

    if (SKID != 0) begin : g_skid
        state_t          state_q;
        state_t          state_d;
        logic            load_m;
        logic            load_k;
        logic            move_k;
        logic            in_fire;
        logic            out_fire;
        logic            in_ready_q;
        logic            out_valid_q;
        logic [XLEN-1:0] k_imm;
        logic [TAG_W-1:0] k_tag;
        logic            k_ill;

        assign in_fire   = in_valid && in_ready_q;
        assign out_fire  = out_valid_q && out_ready;
        assign in_ready  = in_ready_q;
        assign out_valid = out_valid_q;

        // Occupancy FSM: M holds the head entry, K catches one entry under stall.
        always_comb begin
            state_d = state_q;
            load_m  = 1'b0;
            load_k  = 1'b0;
            move_k  = 1'b0;
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        load_m  = 1'b1;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_m = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end else if (in_fire) begin
                        load_k  = 1'b1;
                        state_d = TWO;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        move_k  = 1'b1;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        // in_ready/out_valid are flopped copies of the next-state decode.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q     <= EMPTY;
                in_ready_q  <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                state_q     <= state_d;
                in_ready_q  <= (state_d != TWO);
                out_valid_q <= (state_d != EMPTY);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                out_imm     <= '0;
                out_tag     <= '0;
                out_illegal <= 1'b0;
                k_imm       <= '0;
                k_tag       <= '0;
                k_ill       <= 1'b0;
            end else begin
                if (load_m) begin
                    out_imm     <= exp_imm;
                    out_tag     <= in_tag;
                    out_illegal <= exp_ill;
                end else if (move_k) begin
                    out_imm     <= k_imm;
                    out_tag     <= k_tag;
                    out_illegal <= k_ill;
                end
                if (load_k) begin
                    k_imm <= exp_imm;
                    k_tag <= in_tag;
                    k_ill <= exp_ill;
                end
            end
        end
    end else begin : g_single
        // Reset gates acceptance so nothing slips in while rst is held.
        assign in_ready = !rst && (!out_valid || out_ready);

        always_ff @(posedge clk) begin
            if (rst) begin
                out_valid   <= 1'b0;
                out_imm     <= '0;
                out_tag     <= '0;
                out_illegal <= 1'b0;
            end else if (in_valid && in_ready) begin
                out_valid   <= 1'b1;
                out_imm     <= exp_imm;
                out_tag     <= in_tag;
                out_illegal <= exp_ill;
            end else if (out_ready) begin
                out_valid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: XLEN=32/SKID=1 instance plus an XLEN=64/SKID=0 instance on
// shared stimulus.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_src;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm;
    logic [4:0]  out_tag;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [4:0]  out_tag64;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .SKID(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_tag(out_tag), .out_illegal(out_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .SKID(0)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_tag(out_tag64), .out_illegal(out_illegal64)
    );

    logic [31:0] fmt_instr [5] = '{32'h123450B7, 32'h800000B7, 32'h0080006F,
                                   32'h0002D073, 32'hFFFFFFFF};
    logic [2:0]  fmt_src   [5] = '{3'b011, 3'b011, 3'b100, 3'b101, 3'b101};
    logic [31:0] fmt_exp32 [5] = '{32'h12345000, 32'h80000000, 32'h00000008,
                                   32'h00000005, 32'h0000001F};
    logic [63:0] fmt_exp64 [5] = '{64'h0000000012345000, 64'hFFFFFFFF80000000,
                                   64'h8, 64'h5, 64'h1F};

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_imm_src = '0; in_tag = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_imm !== 32'h0) begin n_fail++; $display("FAIL rst_out_imm got %h want 0", out_imm); end
        n_checks++; if (out_tag !== 5'h0) begin n_fail++; $display("FAIL rst_out_tag got %h want 0", out_tag); end
        n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL rst_out_illegal got %b want 0", out_illegal); end
        n_checks++; if (in_ready64 !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready64 got %b want 0", in_ready64); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_out_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready64 !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready64 got %b want 1", in_ready64); end
    endtask

    task automatic test_i_format();
        out_ready = 1'b1; in_valid = 1'b1;
        in_instr = 32'hFFF00093; in_imm_src = 3'b000; in_tag = 5'd7;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL i_valid got %b want 1", out_valid); end
        n_checks++; if (out_imm !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL i_imm got %h want ffffffff", out_imm); end
        n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL i_illegal got %b want 0", out_illegal); end
        n_checks++; if (out_tag !== 5'd7) begin n_fail++; $display("FAIL i_tag got %0d want 7", out_tag); end
        n_checks++; if (out_imm64 !== 64'hFFFFFFFFFFFFFFFF) begin n_fail++; $display("FAIL i_imm64 got %h want ffffffffffffffff", out_imm64); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL i_drain got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b1;
        in_instr = 32'hFE21AE23; in_imm_src = 3'b001; in_tag = 5'd1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL s_imm got v=%b %h want v=1 fffffffc", out_valid, out_imm); end
        n_checks++; if (out_tag !== 5'd1) begin n_fail++; $display("FAIL s_tag got %0d want 1", out_tag); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
        in_instr = 32'hFE000EE3; in_imm_src = 3'b010; in_tag = 5'd2;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL b_imm got v=%b %h want v=1 fffffffc", out_valid, out_imm); end
        n_checks++; if (out_tag !== 5'd2) begin n_fail++; $display("FAIL b_tag got %0d want 2", out_tag); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_formats();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_instr = fmt_instr[i]; in_imm_src = fmt_src[i]; in_tag = 5'(i + 8);
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++; if (out_valid !== 1'b1 || out_imm !== fmt_exp32[i] || out_illegal !== 1'b0)
                begin n_fail++; $display("FAIL fmt%0d_imm32 got v=%b %h ill=%b want v=1 %h ill=0", i, out_valid, out_imm, out_illegal, fmt_exp32[i]); end
            n_checks++; if (out_valid64 !== 1'b1 || out_imm64 !== fmt_exp64[i] || out_tag64 !== 5'(i + 8))
                begin n_fail++; $display("FAIL fmt%0d_imm64 got v=%b %h tag=%0d want v=1 %h tag=%0d", i, out_valid64, out_imm64, out_tag64, fmt_exp64[i], i + 8); end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        for (int s = 6; s < 8; s++) begin
            in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_imm_src = 3'(s); in_tag = 5'd3;
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++; if (out_valid !== 1'b1 || out_imm !== 32'h0 || out_illegal !== 1'b1)
                begin n_fail++; $display("FAIL ill%0d got v=%b %h ill=%b want v=1 0 ill=1", s, out_valid, out_imm, out_illegal); end
            n_checks++; if (out_imm64 !== 64'h0 || out_illegal64 !== 1'b1)
                begin n_fail++; $display("FAIL ill%0d_64 got %h ill=%b want 0 ill=1", s, out_imm64, out_illegal64); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; in_imm_src = 3'b000;
        in_tag = 5'd1; if (in_ready) acc++;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1 || out_tag !== 5'd1) begin n_fail++; $display("FAIL bp_one got rdy=%b tag=%0d want rdy=1 tag=1", in_ready, out_tag); end
        in_tag = 5'd2; if (in_ready) acc++;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_two_rdy got %b want 0", in_ready); end
        in_tag = 5'd3; if (in_ready) acc++;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 5'd1)
            begin n_fail++; $display("FAIL bp_hold got rdy=%b v=%b tag=%0d want rdy=0 v=1 tag=1", in_ready, out_valid, out_tag); end
        n_checks++; if (acc !== 2) begin n_fail++; $display("FAIL bp_accepts got %0d want 2", acc); end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_tag !== 5'd2) begin n_fail++; $display("FAIL bp_out2 got v=%b tag=%0d want v=1 tag=2", out_valid, out_tag); end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_tag !== 5'd3) begin n_fail++; $display("FAIL bp_out3 got v=%b tag=%0d want v=1 tag=3", out_valid, out_tag); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_reset_in_two();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; in_imm_src = 3'b000; in_tag = 5'd4;
        @(negedge clk);
        in_tag = 5'd5;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL two_rdy got %b want 0", in_ready); end
        rst = 1'b1; in_tag = 5'd6;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_tag !== 5'd0)
            begin n_fail++; $display("FAIL rst_two got v=%b rdy=%b tag=%0d want v=0 rdy=0 tag=0", out_valid, in_ready, out_tag); end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin n_fail++; $display("FAIL rst_two_after got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid); end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_two_flushed got %b want 0", out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_i_format();
        test_back_to_back();
        test_formats();
        test_illegal();
        test_backpressure();
        test_reset_in_two();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
